// File: rtl/pair_stim_gen_if.sv
// Control/status bundle for pair_stim_gen: table write port, playback control,
// and the driven a/b pair with its status flags.
interface pair_stim_gen_if #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              wr_a;
  logic              wr_b;
  logic [HOLD_W-1:0] wr_hold;
  logic [AW:0]       len;
  logic              start;
  logic              loop;
  logic              stop;
  logic              a_out;
  logic              b_out;
  logic              valid;
  logic [AW-1:0]     step_idx;
  logic              busy;
  logic              done;
  logic              eq;
  logic [15:0]       mism_cnt;

  modport master (
    output wr_en, wr_addr, wr_a, wr_b, wr_hold, len, start, loop, stop,
    input  a_out, b_out, valid, step_idx, busy, done, eq, mism_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, wr_hold, len, start, loop, stop,
    output a_out, b_out, valid, step_idx, busy, done, eq, mism_cnt
  );
endinterface

// File: rtl/pair_stim_gen.sv
// Table-driven stimulus source for the (a, b) pair: plays {a, b, hold} entries
// with per-entry hold times, optional looping, and a saturating mismatch count.
module pair_stim_gen #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  pair_stim_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FIN} state_t;

  state_t                        r_state;
  logic [DEPTH-1:0]              r_ta, r_tb;
  logic [DEPTH-1:0][HOLD_W-1:0]  r_th;
  logic                          r_a, r_b, r_valid, r_busy, r_done;
  logic [AW-1:0]                 r_step;
  logic [HOLD_W-1:0]             r_cnt;
  logic [AW:0]                   r_len;
  logic [15:0]                   r_mism;

  logic [AW:0]   w_len_eff;
  logic          w_last;
  logic [AW-1:0] w_nidx;

  assign w_len_eff = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  assign w_last    = (({1'b0, r_step} + (AW+1)'(1)) >= r_len);
  assign w_nidx    = w_last ? '0 : r_step + (AW)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ta    <= '0;
      r_tb    <= '0;
      r_th    <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mism  <= '0;
    end else begin
      r_done <= 1'b0;
      // Counts the cycle that is ending; valid is never high in IDLE, so the
      // clear on start below cannot collide with an increment.
      if (r_valid && (r_a != r_b) && (r_mism != 16'hFFFF))
        r_mism <= r_mism + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.wr_en) begin
            r_ta[bus.wr_addr] <= bus.wr_a;
            r_tb[bus.wr_addr] <= bus.wr_b;
            r_th[bus.wr_addr] <= bus.wr_hold;
          end
          if (bus.start && !bus.stop) begin
            r_mism <= '0;
            r_len  <= w_len_eff;
            r_step <= '0;
            if (w_len_eff == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PLAY;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_a     <= r_ta[0];
              r_b     <= r_tb[0];
              r_cnt   <= r_th[0];
            end
          end
        end
        S_PLAY: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - (HOLD_W)'(1);
          end else if (!w_last || bus.loop) begin
            r_step <= w_nidx;
            r_a    <= r_ta[w_nidx];
            r_b    <= r_tb[w_nidx];
            r_cnt  <= r_th[w_nidx];
          end else begin
            r_state <= S_FIN;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_out    = r_a;
  assign bus.b_out    = r_b;
  assign bus.valid    = r_valid;
  assign bus.step_idx = r_step;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.eq       = r_valid && (r_a == r_b);
  assign bus.mism_cnt = r_mism;
endmodule

// File: tb/tb_pair_stim_gen.sv
// Scoreboard bench for pair_stim_gen: a table-level model expands each run into
// the expected per-cycle output list; a negedge monitor pops and compares.
module tb_pair_stim_gen;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        valid, done, busy, a, b, eq;
    logic [2:0]  step;
    logic [15:0] mism;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pair_stim_gen_if #(.DEPTH(DEPTH), .HOLD_W(8)) bus();
  pair_stim_gen #(.DEPTH(DEPTH), .HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  obs_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference table and retained output state
  logic       ma[DEPTH];
  logic       mb[DEPTH];
  int         mh[DEPTH];
  logic       last_a, last_b;
  logic [2:0] last_step;
  int         exp_mism;

  function automatic obs_t sample();
    obs_t o;
    o.valid = bus.valid; o.done = bus.done; o.busy = bus.busy;
    o.a = bus.a_out; o.b = bus.b_out; o.eq = bus.eq;
    o.step = bus.step_idx; o.mism = bus.mism_cnt;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.valid || bus.done)) begin
      obs_t got, want;
      got = sample();
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %h expected nothing", got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL cycle_output: got %h expected %h", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int addr, input logic a, input logic b, input int h);
    bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_a = a; bus.wr_b = b; bus.wr_hold = 8'(h);
    tick();
    bus.wr_en = 1'b0;
    ma[addr] = a; mb[addr] = b; mh[addr] = h;
  endtask

  function automatic int pass_len(input int len);
    int le = (len > DEPTH) ? DEPTH : len;
    int s = 0;
    for (int i = 0; i < le; i++) s += mh[i] + 1;
    return s;
  endfunction

  // Expand one run into the cycle-by-cycle list the DUT should present.
  task automatic build(input int len, input int passes, input int stop_at);
    int le = (len > DEPTH) ? DEPTH : len;
    int c = 0;
    int m = 0;
    bit cut = 0;
    obs_t o;
    if (le == 0) last_step = 3'd0;
    for (int p = 0; p < passes && !cut; p++)
      for (int i = 0; i < le && !cut; i++)
        for (int k = 0; k <= mh[i] && !cut; k++) begin
          c++;
          if (stop_at != 0 && c > stop_at) cut = 1;
          else begin
            o = '{valid:1'b1, done:1'b0, busy:1'b1, a:ma[i], b:mb[i],
                  eq:(ma[i] == mb[i]), step:3'(i), mism:16'(m)};
            q.push_back(o);
            if (ma[i] != mb[i]) m++;
            last_a = ma[i]; last_b = mb[i]; last_step = 3'(i);
          end
        end
    if (stop_at == 0 || c < stop_at) begin
      o = '{valid:1'b0, done:1'b1, busy:1'b0, a:last_a, b:last_b,
            eq:1'b0, step:last_step, mism:16'(m)};
      q.push_back(o);
    end
    exp_mism = m;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin ma[i] = 0; mb[i] = 0; mh[i] = 0; end
    last_a = 0; last_b = 0; last_step = 0; exp_mism = 0;
  endtask

  task automatic run(input int len, input int passes, input int stop_at,
                     input int inj, input int rst_at);
    int L = pass_len(len);
    int total = (stop_at != 0) ? stop_at : passes * L;
    obs_t idle;
    build(len, passes, stop_at);
    bus.len = 4'(len); bus.loop = (passes > 1); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      bus.loop = (c <= (passes - 1) * L);
      if (c == stop_at) bus.stop = 1'b1;
      if (c == inj) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_a = ~ma[0]; bus.wr_b = ~mb[0];
        bus.wr_hold = 8'd3; bus.start = 1'b1;
      end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_play", 32'(sample()), 32'(0));
        q.delete();
        clear_model();
        #3 rst_n = 1'b1;
        tick();
        return;
      end
      tick();
      bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    end
    bus.loop = 1'b0;
    tick();
    idle = '{valid:1'b0, done:1'b0, busy:1'b0, a:last_a, b:last_b,
             eq:1'b0, step:last_step, mism:16'(exp_mism)};
    chk("end_state", 32'(sample()), 32'(idle));
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_a = 0; bus.wr_b = 0; bus.wr_hold = 0;
    bus.len = 0; bus.start = 0; bus.loop = 0; bus.stop = 0;
    clear_model();
    #1 chk("reset_state", 32'(sample()), 32'(0));
    #6 rst_n = 1'b1;
    tick();

    wr(0, 1, 1, 9); wr(1, 0, 1, 9); wr(2, 1, 0, 9);
    run(3, 1, 0, 0, 0);
    chk("mism_single_pass", bus.mism_cnt, 20);
    run(3, 2, 0, 0, 0);
    chk("mism_two_pass", bus.mism_cnt, 40);
    run(0, 1, 0, 0, 0);
    chk("mism_len0", bus.mism_cnt, 0);
    run(3, 1, 15, 0, 0);
    chk("mism_stopped", bus.mism_cnt, 5);
    chk("hold_after_stop", {bus.a_out, bus.b_out}, 2'b01);
    run(3, 1, 0, 7, 0);
    run(15, 1, 0, 0, 0);

    for (int it = 0; it < 25; it++) begin
      int len, passes, L, stop_at, inj;
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, DEPTH - 1), 1'($urandom), 1'($urandom), $urandom_range(0, 4));
      len = $urandom_range(0, 15);
      passes = $urandom_range(1, 3);
      L = pass_len(len);
      stop_at = (L > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, L * passes) : 0;
      inj = (L > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, L) : 0;
      if (stop_at != 0 && inj > stop_at) inj = 0;
      run(len, passes, stop_at, inj, 0);
    end

    wr(0, 1, 1, 9); wr(1, 0, 1, 9); wr(2, 1, 0, 9);
    run(3, 1, 0, 0, 25);
    run(1, 1, 0, 0, 0);
    chk("replay_after_reset", bus.mism_cnt, 0);

    repeat (3) tick();
    chk("final_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
